sram_port_arbiter: RTL and testbench

Shares the single RW port (port 0) of the `sram` macro between two requesters, e.g. the core data port (req0) and a loader/DMA (req1). Each requester uses a valid/ready request channel and a valid/ready response channel. Round-robin grants are issued one per cycle, and the arbiter drives the macro's active-low controls directly. It tracks one outstanding access per requester and holds read data when a response is back-pressured.

---
 rtl/sram_port_arbiter_pkg.sv | 22 ++
 rtl/sram_rsp_slot.sv | 72 +++++++
 rtl/sram_port_arbiter.sv | 110 +++++++++++
 tb/tb_sram_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester arbiter on the sram RW port.
package sram_port_arbiter_pkg;

    localparam int BYTE_W         = 8;
    localparam int ADDR_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_WMASKS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        INFLIGHT,
        HOLD
    } slot_state_e;

    typedef struct packed {
        logic                      we;
        logic [NUM_WMASKS_DEF-1:0] wmask;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_rsp_slot.sv
// One requester's response slot: tracks a single outstanding access and
// holds read data while the response is back-pressured.
module sram_rsp_slot
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  grant,
    input  logic                  we,
    input  logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  eligible_base
);

    slot_state_e           r_state;
    slot_state_e           w_next;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] w_live_rdata;
    logic                  w_load_hold;

    // Write acknowledgements carry zero; reads pass the macro output through.
    assign w_live_rdata = r_we ? '0 : sram_dout0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_load_hold = 1'b0;
        case (r_state)
            IDLE:     if (grant) w_next = INFLIGHT;
            INFLIGHT: begin
                if (rsp_ready) begin
                    w_next = grant ? INFLIGHT : IDLE;
                end else begin
                    w_next      = HOLD;
                    w_load_hold = 1'b1;
                end
            end
            HOLD:     if (rsp_ready) w_next = grant ? INFLIGHT : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if (grant)       r_we   <= we;
            if (w_load_hold) r_hold <= w_live_rdata;
        end
    end

    always_comb begin
        rsp_valid = (r_state != IDLE);
        case (r_state)
            INFLIGHT: rsp_rdata = w_live_rdata;
            HOLD:     rsp_rdata = r_hold;
            default:  rsp_rdata = '0;
        endcase
    end

    assign eligible_base = (r_state == IDLE) | (rsp_valid & rsp_ready);

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing sram RW port 0 between two valid/ready
// requesters, driving the macro's active-low controls combinationally.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_WMASKS = NUM_WMASKS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    logic w_base0, w_base1;
    logic w_elig0, w_elig1;
    logic w_grant0, w_grant1;
    logic r_ptr;  // 0 = req0 preferred, 1 = req1 preferred
    req_t w_req0, w_req1, w_sel;

    assign w_req0 = '{we: req0_we, wmask: req0_wmask, addr: req0_addr, wdata: req0_wdata};
    assign w_req1 = '{we: req1_we, wmask: req1_wmask, addr: req1_addr, wdata: req1_wdata};

    assign w_elig0 = req0_valid & w_base0;
    assign w_elig1 = req1_valid & w_base1;

    // Grants are suppressed while reset is held so the macro stays deselected.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            if (w_elig0 && (!w_elig1 || !r_ptr)) w_grant0 = 1'b1;
            else if (w_elig1)                    w_grant1 = 1'b1;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_ptr <= 1'b0;
        else if (w_grant0) r_ptr <= 1'b1;
        else if (w_grant1) r_ptr <= 1'b0;
    end

    assign w_sel = w_grant1 ? w_req1 : w_req0;

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (w_grant0 || w_grant1) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~w_sel.we;
            sram_wmask0 = w_sel.we ? w_sel.wmask : '0;
            sram_addr0  = w_sel.addr;
            sram_din0   = w_sel.wdata;
        end
    end

    sram_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
        .clock         (clock),
        .reset         (reset),
        .grant         (w_grant0),
        .we            (req0_we),
        .rsp_ready     (rsp0_ready),
        .sram_dout0    (sram_dout0),
        .rsp_valid     (rsp0_valid),
        .rsp_rdata     (rsp0_rdata),
        .eligible_base (w_base0)
    );

    sram_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
        .clock         (clock),
        .reset         (reset),
        .grant         (w_grant1),
        .we            (req1_we),
        .rsp_ready     (rsp1_ready),
        .sram_dout0    (sram_dout0),
        .rsp_valid     (rsp1_valid),
        .rsp_rdata     (rsp1_rdata),
        .eligible_base (w_base1)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: sram macro model, transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_sram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [3:0]  req0_wmask = '0, req1_wmask = '0;
    logic [12:0] req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [12:0] sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = '0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sram_port_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    // sram macro model: pins captured in cycle N, access performed at the negedge inside N+1.
    logic [31:0] mem     [0:8191];
    logic [31:0] ref_mem [0:8191];
    logic        acc_en = 1'b0, acc_we = 1'b0;
    logic [3:0]  acc_mask = '0;
    logic [12:0] acc_addr = '0;
    logic [31:0] acc_din = '0;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        mem[13'h010] = 32'hDEADBEEF; ref_mem[13'h010] = 32'hDEADBEEF;
        mem[13'h020] = 32'hAABBCCDD; ref_mem[13'h020] = 32'hAABBCCDD;
        mem[13'h030] = 32'h12345678; ref_mem[13'h030] = 32'h12345678;
        mem[13'h040] = 32'hCAFEF00D; ref_mem[13'h040] = 32'hCAFEF00D;
    end

    always @(negedge clock) begin
        if (acc_en && !acc_we) begin
            sram_dout0 = mem[acc_addr];
        end else begin
            sram_dout0 = $urandom;
            if (acc_en)
                for (int b = 0; b < 4; b++)
                    if (acc_mask[b]) mem[acc_addr][8*b +: 8] = acc_din[8*b +: 8];
        end
        #2;
        acc_en   = !sram_csb0;
        acc_we   = !sram_web0;
        acc_mask = sram_wmask0;
        acc_addr = sram_addr0;
        acc_din  = sram_din0;
    end

    // Reference model: one pending response per requester, expected data fixed at grant time.
    logic        m_pend [2];
    logic [31:0] m_data [2];
    logic        m_ptr;

    initial begin
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        m_data[0] = '0;   m_data[1] = '0;
        m_ptr = 1'b0;
    end

    always @(negedge clock) begin
        logic e0, e1, g0, g1, gw;
        logic [3:0]  gm;
        logic [12:0] ga;
        logic [31:0] gd;
        #1;
        if (reset) begin
            m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_ptr = 1'b0;
            check("rst_rdata0", rsp0_rdata, 32'h0);
            check("rst_rdata1", rsp1_rdata, 32'h0);
        end
        e0 = !reset && req0_valid && (!m_pend[0] || rsp0_ready);
        e1 = !reset && req1_valid && (!m_pend[1] || rsp1_ready);
        g0 = e0 && (!e1 || !m_ptr);
        g1 = e1 && !g0;
        gw = g0 ? req0_we    : req1_we;
        gm = g0 ? req0_wmask : req1_wmask;
        ga = g0 ? req0_addr  : req1_addr;
        gd = g0 ? req0_wdata : req1_wdata;

        check("m_ready0", 32'(req0_ready), 32'(g0));
        check("m_ready1", 32'(req1_ready), 32'(g1));
        check("m_rspv0", 32'(rsp0_valid), 32'(m_pend[0]));
        check("m_rspv1", 32'(rsp1_valid), 32'(m_pend[1]));
        if (m_pend[0]) check("m_rdata0", rsp0_rdata, m_data[0]);
        if (m_pend[1]) check("m_rdata1", rsp1_rdata, m_data[1]);
        if (g0 || g1) begin
            check("m_csb", 32'(sram_csb0), 32'h0);
            check("m_web", 32'(sram_web0), 32'(!gw));
            check("m_wmask", 32'(sram_wmask0), gw ? 32'(gm) : 32'h0);
            check("m_addr", 32'(sram_addr0), 32'(ga));
            check("m_din", sram_din0, gd);
        end else begin
            check("m_csb_idle", 32'(sram_csb0), 32'h1);
            check("m_web_idle", 32'(sram_web0), 32'h1);
            check("m_pins_idle", {sram_wmask0, 15'h0, sram_addr0} | sram_din0, 32'h0);
        end

        if (!reset) begin
            if (m_pend[0] && rsp0_ready) m_pend[0] = 1'b0;
            if (m_pend[1] && rsp1_ready) m_pend[1] = 1'b0;
            if (g0 || g1) begin
                m_pend[g1 ? 1 : 0] = 1'b1;
                m_data[g1 ? 1 : 0] = gw ? 32'h0 : ref_mem[ga];
                if (gw)
                    for (int b = 0; b < 4; b++)
                        if (gm[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
                m_ptr = g0;
            end
        end
    end

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_mid();
        @(negedge clock);
        #2;
    endtask

    task automatic drive_req(input int r, input logic v, input logic we, input logic [3:0] m,
                             input logic [12:0] a, input logic [31:0] d);
        if (r == 0) begin
            req0_valid = v; req0_we = we; req0_wmask = m; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_wmask = m; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Presents one request, waits for its grant (bounded), then drops valid.
    task automatic issue(input int r, input logic we, input logic [3:0] m,
                         input logic [12:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        drive_req(r, 1'b1, we, m, a, d);
        for (int k = 0; k < 20 && !got; k++) begin
            wait_mid();
            got = (r == 0) ? req0_ready : req1_ready;
            if (got) check("grant_csb", 32'(sram_csb0), 32'h0);
            next_cyc();
        end
        check("grant_timeout", 32'(got), 32'h1);
        drive_req(r, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cyc();
        next_cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic g0, g1;
        logic [12:0] a0, a1;

        next_cyc();
        wait_mid();
        check("reset_csb", 32'(sram_csb0), 32'h1);
        check("reset_web", 32'(sram_web0), 32'h1);
        check("reset_rspv", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
        next_cyc();
        reset = 1'b0;
        next_cyc();

        // Single read
        rsp0_ready = 1'b1;
        issue(0, 1'b0, 4'h0, 13'h010, 32'h0);
        wait_mid();
        check("rd_valid", 32'(rsp0_valid), 32'h1);
        check("rd_data", rsp0_rdata, 32'hDEADBEEF);
        check("rd_csb_after", 32'(sram_csb0), 32'h1);
        next_cyc();

        // Masked write then read back
        rsp1_ready = 1'b1;
        issue(1, 1'b1, 4'b0101, 13'h020, 32'h11223344);
        wait_mid();
        check("wr_ack_valid", 32'(rsp1_valid), 32'h1);
        check("wr_ack_data", rsp1_rdata, 32'h0);
        next_cyc();
        issue(1, 1'b0, 4'h0, 13'h020, 32'h0);
        wait_mid();
        check("wr_readback", rsp1_rdata, 32'hAA22CC44);
        next_cyc();

        // Contention: alternating grants starting with req0 after reset
        do_reset();
        a0 = 13'h200;
        a1 = 13'h300;
        drive_req(0, 1'b1, 1'b0, 4'h0, a0, 32'h0);
        drive_req(1, 1'b1, 1'b0, 4'h0, a1, 32'h0);
        for (int k = 0; k < 6; k++) begin
            wait_mid();
            check("rr_g0", 32'(req0_ready), 32'(k % 2 == 0));
            check("rr_g1", 32'(req1_ready), 32'(k % 2 == 1));
            if (k > 0 && k % 2 == 1) check("rr_rsp0", rsp0_rdata, init_val(int'(a0) - 1));
            g0 = req0_ready;
            g1 = req1_ready;
            next_cyc();
            if (g0) begin a0++; req0_addr = a0; end
            if (g1) begin a1++; req1_addr = a1; end
        end
        drive_req(0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        next_cyc();

        // Backpressure: held read data survives an overwrite of the same word
        rsp0_ready = 1'b0;
        issue(0, 1'b0, 4'h0, 13'h030, 32'h0);
        drive_req(0, 1'b1, 1'b0, 4'h0, 13'h031, 32'h0);
        drive_req(1, 1'b1, 1'b1, 4'hF, 13'h030, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_mid();
            check("bp_valid", 32'(rsp0_valid), 32'h1);
            check("bp_hold", rsp0_rdata, 32'h12345678);
            check("bp_no_grant0", 32'(req0_ready), 32'h0);
            next_cyc();
        end
        drive_req(1, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        rsp0_ready = 1'b1;
        issue(0, 1'b0, 4'h0, 13'h031, 32'h0);
        next_cyc();
        check("bp_overwritten", mem[13'h030], 32'h0);

        // Back-to-back reads from req0
        a0 = 13'h100;
        drive_req(0, 1'b1, 1'b0, 4'h0, a0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            wait_mid();
            check("b2b_grant", 32'(req0_ready), 32'h1);
            if (k > 0) check("b2b_data", rsp0_rdata, init_val(32'h100 + k - 1));
            next_cyc();
            a0++;
            req0_addr = a0;
        end
        drive_req(0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        wait_mid();
        check("b2b_last", rsp0_rdata, init_val(32'h107));
        next_cyc();
        next_cyc();

        // Reset in the cycle after a grant
        issue(0, 1'b0, 4'h0, 13'h040, 32'h0);
        reset = 1'b1;
        drive_req(1, 1'b1, 1'b0, 4'h0, 13'h041, 32'h0);
        wait_mid();
        check("mr_rspv0", 32'(rsp0_valid), 32'h0);
        check("mr_csb", 32'(sram_csb0), 32'h1);
        check("mr_ready1", 32'(req1_ready), 32'h0);
        next_cyc();
        next_cyc();
        drive_req(1, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_mid();
            check("mr_no_stale", 32'(rsp0_valid), 32'h0);
            next_cyc();
        end
        drive_req(0, 1'b1, 1'b0, 4'h0, 13'h040, 32'h0);
        drive_req(1, 1'b1, 1'b0, 4'h0, 13'h041, 32'h0);
        wait_mid();
        check("mr_ptr_g0", 32'(req0_ready), 32'h1);
        check("mr_ptr_g1", 32'(req1_ready), 32'h0);
        next_cyc();
        drive_req(0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        wait_mid();
        check("mr_fresh", rsp0_rdata, 32'hCAFEF00D);
        check("mr_next_g1", 32'(req1_ready), 32'h1);
        next_cyc();
        drive_req(1, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        next_cyc();
        next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
